// File: rtl/serdac_pkg.sv
// serdac_pkg: shared definitions for the multi-channel serial DAC controller.
//   state_e          FSM state encoding (also exported on the debug port)
//   OP_WRITE/OP_RDBK COMMAND opcode values
//   CMD_*            COMMAND field bit positions
//   *_CNT_W          counter widths sized for the largest legal DIV / WIDTH
package serdac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_FINISH = 3'd3,
    ST_ACK    = 3'd4
  } state_e;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_RDBK  = 2'b01;

  localparam int CMD_OP_MSB = 9;
  localparam int CMD_OP_LSB = 8;
  localparam int CMD_CH_MSB = 3;
  localparam int CMD_CH_LSB = 0;

  // DIV <= 255 and WIDTH <= 32, so these widths hold DIV-1 and WIDTH-1.
  localparam int DIV_CNT_W = 8;
  localparam int BIT_CNT_W = 5;

endpackage

// File: rtl/serdac_shifter.sv
// serdac_shifter: WIDTH-bit parallel-load, serial-in (LSB), serial-out (MSB)
// shift register. With TMR=1 the register is kept in three copies and the
// output is the bitwise majority; every update is computed from the voted
// value so a single upset copy is scrubbed on the next write.
//   MIDCLK  in   clock (rising edge)
//   RST     in   asynchronous active-high reset, clears the register
//   load    in   load din (has priority over shift)
//   shift   in   shift left by one, sin enters at bit 0
//   din     in   parallel load word
//   sin     in   serial input
//   q       out  register contents (voted when TMR=1)
module serdac_shifter
  import serdac_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TMR   = 0
) (
  input  logic             MIDCLK,
  input  logic             RST,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  localparam int NR = (TMR == 1) ? 3 : 1;

  logic [WIDTH-1:0] r [NR];

  always_ff @(posedge MIDCLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NR; i++) r[i] <= '0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (load)       r[i] <= din;
        else if (shift) r[i] <= {q[WIDTH-2:0], sin};
      end
    end
  end

  generate
    if (NR == 3) begin : g_vote
      assign q = (r[0] & r[1]) | (r[0] & r[2]) | (r[1] & r[2]);
    end else begin : g_single
      assign q = r[0];
    end
  endgenerate

endmodule

// File: rtl/serdac_mc.sv
// serdac_mc: VME-side controller that writes a WIDTH-bit word to one of NCH
// serial DACs and captures the word the DAC shifts back.
//   MIDCLK     in   clock, rising edge only
//   RST        in   asynchronous active-high reset
//   STROBE     in   VME data strobe (level)
//   DEVICE     in   board select
//   COMMAND    in   [9:8] opcode (00 write, 01 read-back ack), [3:0] channel
//   INDATA     in   word to send, captured when the transfer starts
//   DACOUT     in   serial data from the selected DAC
//   DACCS_B    out  active-low chip selects, at most one low
//   DACCLK     out  serial clock, idles low
//   DACDATA    out  serial data, MSB first, 0 when not busy
//   OUTDATA    out  last word captured from DACOUT
//   BUSY       out  high in LOAD, SHIFT and FINISH
//   DTACK_B    out  0 while acknowledging, released (high-Z) otherwise
//   DBG_STATE  out  current FSM state
//
// Bus handshake: a request is taken on a MIDCLK edge where STROBE=1,
// DEVICE=1, the opcode and channel are legal and the FSM is IDLE. The FSM
// then holds DTACK_B low in ACK until it samples STROBE=0 and returns to
// IDLE, so a strobe held high across the acknowledge can never start a
// second transfer. Dropping STROBE early does not abort a write.
//
// Serial timing per bit: DACCLK low for DIV cycles, high for DIV cycles.
// DACOUT is shifted in on the edge that raises DACCLK; DACDATA advances on
// the edge that lowers it. DACCLK itself serves as the half-period phase.
module serdac_mc
  import serdac_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NCH   = 4,
  parameter int DIV   = 1,
  parameter int TMR   = 0
) (
  input  logic             MIDCLK,
  input  logic             RST,
  input  logic             STROBE,
  input  logic             DEVICE,
  input  logic [9:0]       COMMAND,
  input  logic [WIDTH-1:0] INDATA,
  input  logic             DACOUT,
  output logic [NCH-1:0]   DACCS_B,
  output logic             DACCLK,
  output logic             DACDATA,
  output logic [WIDTH-1:0] OUTDATA,
  output logic             BUSY,
  output wire              DTACK_B,
  output state_e           DBG_STATE
);

  localparam int NR = (TMR == 1) ? 3 : 1;
  localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(DIV - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(WIDTH - 1);

  // Triplicated (when TMR=1) state and counters, plus their voted views.
  state_e               state_r [NR];
  logic [DIV_CNT_W-1:0] div_r   [NR];
  logic [BIT_CNT_W-1:0] bit_r   [NR];
  state_e               state;
  logic [DIV_CNT_W-1:0] div_q;
  logic [BIT_CNT_W-1:0] bit_q;

  // Registered outputs.
  logic [NCH-1:0]   cs_r;
  logic             clk_r, data_r, busy_r, dtack_r;
  logic [WIDTH-1:0] out_r;

  // Next values.
  state_e               state_n;
  logic [DIV_CNT_W-1:0] div_n;
  logic [BIT_CNT_W-1:0] bit_n;
  logic [NCH-1:0]       cs_n;
  logic                 clk_n, data_n, busy_n, dtack_n;
  logic [WIDTH-1:0]     out_n;
  logic                 load_en, shift_en;
  logic [WIDTH-1:0]     sreg;

  logic [1:0]     opcode;
  logic [3:0]     ch;
  logic [NCH-1:0] ch_sel;
  logic           op_ok, ch_ok, accept;
  logic           unused_cmd;

  assign opcode     = COMMAND[CMD_OP_MSB:CMD_OP_LSB];
  assign ch         = COMMAND[CMD_CH_MSB:CMD_CH_LSB];
  assign unused_cmd = ^COMMAND[CMD_OP_LSB-1:CMD_CH_MSB+1];
  assign op_ok      = (opcode == OP_WRITE) || (opcode == OP_RDBK);
  assign ch_ok      = ({1'b0, ch} < 5'(NCH));
  assign accept     = STROBE && DEVICE && op_ok && ch_ok;

  always_comb begin
    ch_sel = '0;
    for (int i = 0; i < NCH; i++) ch_sel[i] = (ch == 4'(i));
  end

  generate
    if (NR == 3) begin : g_vote
      assign state = state_e'((state_r[0] & state_r[1]) | (state_r[0] & state_r[2]) |
                              (state_r[1] & state_r[2]));
      assign div_q = (div_r[0] & div_r[1]) | (div_r[0] & div_r[2]) | (div_r[1] & div_r[2]);
      assign bit_q = (bit_r[0] & bit_r[1]) | (bit_r[0] & bit_r[2]) | (bit_r[1] & bit_r[2]);
    end else begin : g_single
      assign state = state_r[0];
      assign div_q = div_r[0];
      assign bit_q = bit_r[0];
    end
  endgenerate

  always_comb begin
    state_n  = state;
    div_n    = div_q;
    bit_n    = bit_q;
    cs_n     = cs_r;
    clk_n    = clk_r;
    data_n   = data_r;
    busy_n   = busy_r;
    dtack_n  = dtack_r;
    out_n    = out_r;
    load_en  = 1'b0;
    shift_en = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (opcode == OP_WRITE) begin
            state_n = ST_LOAD;
            cs_n    = ~ch_sel;
            data_n  = INDATA[WIDTH-1];
            busy_n  = 1'b1;
            load_en = 1'b1;
          end else begin
            state_n = ST_ACK;
            dtack_n = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        state_n = ST_SHIFT;
        div_n   = '0;
        bit_n   = '0;
      end
      ST_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_n = '0;
          if (!clk_r) begin
            clk_n    = 1'b1;
            shift_en = 1'b1;
          end else begin
            clk_n = 1'b0;
            if (bit_q == BIT_LAST) begin
              // The last rise already shifted in the final DACOUT bit.
              bit_n   = '0;
              state_n = ST_FINISH;
              cs_n    = '1;
              data_n  = 1'b0;
              out_n   = sreg;
            end else begin
              bit_n  = bit_q + 5'd1;
              data_n = sreg[WIDTH-1];
            end
          end
        end else begin
          div_n = div_q + 8'd1;
        end
      end
      ST_FINISH: begin
        state_n = ST_ACK;
        busy_n  = 1'b0;
        dtack_n = 1'b1;
      end
      ST_ACK: begin
        if (!STROBE) begin
          state_n = ST_IDLE;
          dtack_n = 1'b0;
        end
      end
      default: begin
        state_n = ST_IDLE;
        div_n   = '0;
        bit_n   = '0;
        cs_n    = '1;
        clk_n   = 1'b0;
        data_n  = 1'b0;
        busy_n  = 1'b0;
        dtack_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge MIDCLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NR; i++) begin
        state_r[i] <= ST_IDLE;
        div_r[i]   <= '0;
        bit_r[i]   <= '0;
      end
      cs_r    <= '1;
      clk_r   <= 1'b0;
      data_r  <= 1'b0;
      busy_r  <= 1'b0;
      dtack_r <= 1'b0;
      out_r   <= '0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        state_r[i] <= state_n;
        div_r[i]   <= div_n;
        bit_r[i]   <= bit_n;
      end
      cs_r    <= cs_n;
      clk_r   <= clk_n;
      data_r  <= data_n;
      busy_r  <= busy_n;
      dtack_r <= dtack_n;
      out_r   <= out_n;
    end
  end

  serdac_shifter #(
    .WIDTH (WIDTH),
    .TMR   (TMR)
  ) u_shifter (
    .MIDCLK (MIDCLK),
    .RST    (RST),
    .load   (load_en),
    .shift  (shift_en),
    .din    (INDATA),
    .sin    (DACOUT),
    .q      (sreg)
  );

  assign DACCS_B   = cs_r;
  assign DACCLK    = clk_r;
  assign DACDATA   = data_r;
  assign BUSY      = busy_r;
  assign OUTDATA   = out_r;
  assign DTACK_B   = dtack_r ? 1'b0 : 1'bz;
  assign DBG_STATE = state;

endmodule
